memory_responder_axi: RTL
=========================

MEMORY_RESPONDER_AXI -- requirements
Module: memory_responder_axi

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, data bus width in bits (32/64/128/256).
REQ-002 The block SHALL have parameter DEPTH, default 1024, memory depth in WIDTH-bit words (power of two).
REQ-003 The block SHALL have parameter STALL_EN, default 0; 1 enables pseudo-random aready/wready/rvalid/bvalid stalls.
REQ-004 The block SHALL have parameter LFSR_SEED, default 16'hACE1, initial stall-LFSR value (nonzero).
REQ-005 The block SHALL have one clock, axi_clk; reset axi_rst is synchronous and active-high.
REQ-006 Ports, in order:
- axi_clk in 1: clock.
- axi_rst in 1: sync active-high reset.
- aid in 8: transaction ID.
- aaddr in 32: byte address.
- alen in 8: beats-1.
- asize in 3: log2 bytes/beat.
- aburst in 2: burst type.
- alock in 2: ignored.
- avalid in 1: address valid.
- aready out 1: address accept.
- atype in 1: 1 write, 0 read.
- wid in 8: ignored.
- wdata in WIDTH: write data.
- wstrb in WIDTH/8: byte enables.
- wlast in 1: last write beat.
- wvalid in 1: write valid.
- wready out 1: write accept.
- rid out 8: read ID.
- rdata out WIDTH: read data.
- rlast out 1: last read beat.
- rvalid out 1: read valid.
- rready in 1: read accept.
- rresp out 2: read response.
- bid out 8: write-response ID.
- bvalid out 1: write-response valid.
- bready in 1: write-response accept.
- bresp out 2: write response.
- err_cnt out 16: saturating protocol-error count.

Function
REQ-007 FSM states SHALL be IDLE, WDATA, WRESP, RADDR, RDATA; one transaction outstanding at a time.
REQ-008 aready SHALL be 1 only in IDLE (AND stall-LFSR bit 0 when STALL_EN=1); avalid&aready captures aid, alen, aburst, word index = aaddr[...:ASIZE] mod DEPTH; next state WDATA if atype=1 else RADDR.
REQ-009 Word-address arithmetic SHALL wrap modulo DEPTH; aburst 2'b00 (FIXED) holds the index, every other value increments per beat.
REQ-010 The burst SHALL be flagged in error (resp 2'b10 SLVERR, else 2'b00 OKAY) when asize != log2(WIDTH/8), aburst = 2'b10 or 2'b11, or a wlast mismatch occurs; data still transferred.
REQ-011 In WDATA, wready SHALL be 1 (stall-gated); each wvalid&wready beat writes the memory byte lanes selected by wstrb; beat alen+1 ends the burst regardless of wlast.
REQ-012 wlast=1 on a non-final beat or wlast=0 on the final beat SHALL be a wlast mismatch.
REQ-013 After the final write beat, wready SHALL drop next cycle and the FSM SHALL enter WRESP with bvalid=1, bid=captured aid, bresp per REQ-010.
REQ-014 bvalid/bid/bresp SHALL hold stable until bready; on bvalid&bready the FSM SHALL return to IDLE.
REQ-015 RADDR SHALL issue a one-cycle synchronous memory read; RDATA SHALL present rvalid=1 with rdata, rid=captured aid, rresp, rlast=1 on beat alen+1.
REQ-016 rvalid and all R outputs SHALL hold stable until rready; the next beat SHALL follow rvalid&rready with at most one bubble cycle (0 bubbles required when STALL_EN=0).
REQ-017 The final rvalid&rready SHALL return the FSM to IDLE; alen=0 bursts SHALL assert rlast on the single beat.
REQ-018 With STALL_EN=1, a 16-bit Fibonacci LFSR (taps 16,14,13,11) SHALL advance every cycle; stalls never deassert a valid already asserted.
REQ-019 err_cnt SHALL increment once per errored burst, at its response handshake, saturating at 16'hFFFF.
REQ-020 Read-after-write to the same address SHALL return the written data; memory contents are not reset.

Reset
REQ-021 On axi_rst=1 at a clock edge, FSM SHALL go to IDLE and aready, wready, rvalid, rlast, bvalid, rid, bid, rresp, bresp, rdata, err_cnt SHALL be 0; LFSR SHALL load LFSR_SEED.
REQ-022 Reset mid-burst SHALL abandon the burst with no response; memory writes already performed SHALL persist.

Structure
REQ-023 A shared package SHALL hold FSM state encodings, burst-type constants (FIXED/INCR/WRAP) and response constants (OKAY 2'b00, SLVERR 2'b10).
REQ-024 The stall LFSR SHALL be a sub-module named axi_stall_lfsr; memory SHALL be an inferred synchronous single-port RAM.

Verification
REQ-025 WIDTH=32, write aaddr=0x100, alen=3, data 0xA0..0xA3, then read the same -> rdata 0xA0..0xA3, rlast on beat 4, bresp=rresp=00, bid/rid echo aid.
REQ-026 Write 0xFFFFFFFF to word 0, then write 0x12345678 with wstrb=4'b0011 -> read returns 0xFFFF5678.
REQ-027 DEPTH=1024, INCR write aaddr=0xFFC (word 1023), alen=1 -> second beat lands at word 0.
REQ-028 Write with wlast on beat 2 of alen=3 -> bresp=2'b10 after beat 4, err_cnt=1.
REQ-029 STALL_EN=1, rready toggled every cycle, 70-beat burst -> no beat lost/duplicated, R outputs stable while rvalid&!rready.
REQ-030 axi_rst pulsed during beat 2 of alen=7 write -> next cycle all outputs 0, IDLE; a fresh write/read completes with OKAY.

Source files
------------

// File: rtl/memory_responder_axi_pkg.sv
// Shared encodings for the AXI memory responder: FSM states, burst types and
// response codes.
package memory_responder_axi_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/memory_responder_axi_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used to throttle handshakes.
// bit0_next is the value bit 0 will hold after the next clock edge.
module axi_stall_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    output logic bit0_next
);

    logic [15:0] q;
    logic        fb;

    assign fb        = q[15] ^ q[13] ^ q[12] ^ q[10];
    assign bit0_next = fb;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else begin
            q <= {q[14:0], fb};
        end
    end

endmodule

// File: rtl/memory_responder_axi.sv
// Single-outstanding AXI-style memory slave backed by a byte-enabled
// synchronous single-port RAM, with optional pseudo-random handshake stalls.
module memory_responder_axi
    import memory_responder_axi_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter int          DEPTH     = 1024,
    parameter int          STALL_EN  = 0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic               axi_clk,
    input  logic               axi_rst,
    input  logic [7:0]         aid,
    input  logic [31:0]        aaddr,
    input  logic [7:0]         alen,
    input  logic [2:0]         asize,
    input  logic [1:0]         aburst,
    input  logic [1:0]         alock,
    input  logic               avalid,
    output logic               aready,
    input  logic               atype,
    input  logic [7:0]         wid,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [WIDTH/8-1:0] wstrb,
    input  logic               wlast,
    input  logic               wvalid,
    output logic               wready,
    output logic [7:0]         rid,
    output logic [WIDTH-1:0]   rdata,
    output logic               rlast,
    output logic               rvalid,
    input  logic               rready,
    output logic [1:0]         rresp,
    output logic [7:0]         bid,
    output logic               bvalid,
    input  logic               bready,
    output logic [1:0]         bresp,
    output logic [15:0]        err_cnt
);

    localparam int         NB      = WIDTH / 8;
    localparam int         ASIZE   = $clog2(NB);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [2:0] ASIZE_V = 3'(ASIZE);

    state_t            state;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     idx_next;
    logic [AW-1:0]     mem_addr;
    logic [7:0]        len;
    logic [7:0]        beat;
    logic [1:0]        burst;
    logic              err;
    logic              stall_bit;
    logic              go;
    logic              wr_fire;
    logic              r_fire;
    logic              b_fire;
    logic              rd_en;
    logic              w_final;
    logic              w_err;
    logic              unused_bits;
    logic [WIDTH-1:0]  mem [DEPTH];

    axi_stall_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (axi_clk),
        .rst       (axi_rst),
        .bit0_next (stall_bit)
    );

    assign go          = (STALL_EN != 0) ? stall_bit : 1'b1;
    assign unused_bits = ^{alock, wid, aaddr};

    assign idx_next = (burst == BURST_FIXED) ? idx : idx + 1'b1;
    assign wr_fire  = (state == WDATA) && wvalid && wready;
    assign r_fire   = (state == RDATA) && rvalid && rready;
    assign b_fire   = (state == WRESP) && bvalid && bready;
    assign w_final  = (beat == len);
    assign w_err    = (wlast != w_final);

    // Reads prefetch the next beat on the handshake so rdata changes only then.
    assign rd_en    = (state == RADDR) || (r_fire && !rlast);
    assign mem_addr = (state == RDATA) ? idx_next : idx;

    always_ff @(posedge axi_clk) begin
        if (wr_fire && !axi_rst) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb[b]) mem[mem_addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[mem_addr];
        end
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state   <= IDLE;
            aready  <= 1'b0;
            wready  <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            bvalid  <= 1'b0;
            rid     <= 8'h00;
            bid     <= 8'h00;
            rresp   <= RESP_OKAY;
            bresp   <= RESP_OKAY;
            err_cnt <= 16'h0000;
            idx     <= '0;
            len     <= 8'h00;
            beat    <= 8'h00;
            burst   <= BURST_INCR;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    aready <= go;
                    if (avalid && aready) begin
                        aready <= 1'b0;
                        idx    <= aaddr[ASIZE +: AW];
                        len    <= alen;
                        burst  <= aburst;
                        beat   <= 8'h00;
                        err    <= (asize != ASIZE_V) || aburst[1];
                        if (atype) begin
                            state  <= WDATA;
                            wready <= go;
                            bid    <= aid;
                        end else begin
                            state <= RADDR;
                            rid   <= aid;
                        end
                    end
                end
                WDATA: begin
                    wready <= go;
                    if (wr_fire) begin
                        beat <= beat + 8'd1;
                        idx  <= idx_next;
                        if (w_err) err <= 1'b1;
                        // Beat count, not wlast, terminates the burst.
                        if (w_final) begin
                            state  <= WRESP;
                            wready <= 1'b0;
                            bvalid <= go;
                            bresp  <= (err || w_err) ? RESP_SLVERR : RESP_OKAY;
                        end
                    end
                end
                WRESP: begin
                    if (!bvalid) bvalid <= go;
                    if (b_fire) begin
                        bvalid <= 1'b0;
                        state  <= IDLE;
                        aready <= go;
                        if (err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                    end
                end
                RADDR: begin
                    state  <= RDATA;
                    rvalid <= 1'b1;
                    rlast  <= (len == 8'h00);
                    rresp  <= err ? RESP_SLVERR : RESP_OKAY;
                end
                RDATA: begin
                    if (!rvalid) rvalid <= 1'b1;
                    if (r_fire) begin
                        if (rlast) begin
                            rvalid <= 1'b0;
                            rlast  <= 1'b0;
                            state  <= IDLE;
                            aready <= go;
                            if (err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                        end else begin
                            rvalid <= go;
                            beat   <= beat + 8'd1;
                            idx    <= idx_next;
                            rlast  <= ((beat + 8'd1) == len);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
